// File: rtl/pe_buffer_pkg.sv
// pe_buffer_pkg: shared constants, drain FSM encoding and index-width helper for the PE input buffer path.
package pe_buffer_pkg;
    localparam int DEF_WIDTH    = 16;
    localparam int DEF_PAR_READ = 4;
    typedef enum logic {
        ST_EMPTY = 1'b0,
        ST_HOLD  = 1'b1
    } drain_state_t;
    function automatic int idx_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction
endpackage

// File: rtl/buffer_drain_hold_reg.sv
// buffer_drain_hold_reg: holds one buffer read word and selects element idx (element 0 in the top slice).
module buffer_drain_hold_reg
    import pe_buffer_pkg::*;
#(
    parameter int WIDTH    = DEF_WIDTH,
    parameter int PAR_READ = DEF_PAR_READ
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         load,
    input  logic [WIDTH*PAR_READ-1:0]    word,
    input  logic [idx_w(PAR_READ)-1:0]   idx,
    output logic [WIDTH-1:0]             element
);
    logic [WIDTH*PAR_READ-1:0] word_q;
    logic [WIDTH-1:0]          elems [PAR_READ];

    always_ff @(posedge clk) begin
        if (!rst) word_q <= '0;
        else if (load) word_q <= word;
    end

    // buffer bit 0 is the MSB here, so element 0 sits in the top slice
    for (genvar i = 0; i < PAR_READ; i++) begin : g_el
        assign elems[i] = word_q[(PAR_READ-1-i)*WIDTH +: WIDTH];
    end

    assign element = elems[idx];
endmodule

// File: rtl/buffer_drain_unpacker.sv
// buffer_drain_unpacker: drains PAR_READ-element buffer words into a valid/ready stream of single elements.
// Optional BUFFER_DRAIN_LAST_EN adds a FRAME_LEN frame counter and the out_last port.
module buffer_drain_unpacker
    import pe_buffer_pkg::*;
#(
    parameter int WIDTH    = DEF_WIDTH,
    parameter int PAR_READ = DEF_PAR_READ
`ifdef BUFFER_DRAIN_LAST_EN
    ,
    parameter int FRAME_LEN = 9
`endif
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      buf_valid,
    input  logic [WIDTH*PAR_READ-1:0] buf_dout,
    output logic                      buf_ren,
    output logic [WIDTH-1:0]          out_data,
    output logic                      out_valid,
`ifdef BUFFER_DRAIN_LAST_EN
    output logic                      out_last,
`endif
    input  logic                      out_ready
);
    localparam int IW = idx_w(PAR_READ);

    drain_state_t  state, state_n;
    logic [IW-1:0] idx, idx_n;
    logic          accept, at_last;

    assign accept    = (state == ST_HOLD) && out_ready;
    assign at_last   = idx == IW'(PAR_READ - 1);
    assign out_valid = state == ST_HOLD;
    // reset gates the pop combinationally so no word is lost while the buffer resets
    assign buf_ren   = rst && buf_valid && ((state == ST_EMPTY) || (accept && at_last));

    always_ff @(posedge clk) begin
        if (!rst) begin
            state <= ST_EMPTY;
            idx   <= '0;
        end else begin
            state <= state_n;
            idx   <= idx_n;
        end
    end

    always_comb begin
        state_n = state;
        idx_n   = idx;
        if (state == ST_EMPTY) begin
            state_n = buf_valid ? ST_HOLD : ST_EMPTY;
            idx_n   = '0;
        end else if (out_ready) begin
            idx_n   = at_last ? '0 : idx + 1'b1;
            state_n = (at_last && !buf_valid) ? ST_EMPTY : ST_HOLD;
        end
    end

    buffer_drain_hold_reg #(
        .WIDTH   (WIDTH),
        .PAR_READ(PAR_READ)
    ) u_hold (
        .clk    (clk),
        .rst    (rst),
        .load   (buf_ren),
        .word   (buf_dout),
        .idx    (idx),
        .element(out_data)
    );

`ifdef BUFFER_DRAIN_LAST_EN
    localparam int FW = idx_w(FRAME_LEN);
    logic [FW-1:0] fcnt;
    logic          frame_end;

    assign frame_end = fcnt == FW'(FRAME_LEN - 1);
    assign out_last  = out_valid && frame_end;

    always_ff @(posedge clk) begin
        if (!rst) fcnt <= '0;
        else if (accept) fcnt <= frame_end ? '0 : fcnt + 1'b1;
    end
`endif
endmodule

// File: tb/tb_buffer_drain_unpacker.sv
// tb_buffer_drain_unpacker: randomized and directed checks of buffer_drain_unpacker against a queue model.
module tb_buffer_drain_unpacker;
    localparam int W  = 16;
    localparam int P  = 4;
    localparam int FL = 9;

    logic         clk = 1'b0;
    logic         rst = 1'b0;
    logic         buf_valid = 1'b0;
    logic         out_ready = 1'b0;
    logic [W*P-1:0] buf_dout = '0;
    logic         buf_ren, out_valid;
    logic [W-1:0] out_data;
`ifdef BUFFER_DRAIN_LAST_EN
    logic         out_last;
`endif

    int n_cmp = 0;
    int n_err = 0;
    logic [W-1:0] q[$];
    int fc = 0;

    always #5 clk = ~clk;

    buffer_drain_unpacker dut (
        .clk      (clk),
        .rst      (rst),
        .buf_valid(buf_valid),
        .buf_dout (buf_dout),
        .buf_ren  (buf_ren),
        .out_data (out_data),
        .out_valid(out_valid),
`ifdef BUFFER_DRAIN_LAST_EN
        .out_last (out_last),
`endif
        .out_ready(out_ready)
    );

    // reference: q holds the elements of the word currently owned by the consumer
    function automatic bit m_ren();
        return rst && buf_valid && (q.size() == 0 || (out_ready && q.size() == 1));
    endfunction

    function automatic bit m_last();
        return q.size() != 0 && fc == FL - 1;
    endfunction

    task automatic drive(input logic rs, input logic v, input logic r, input logic [W*P-1:0] d);
        @(negedge clk);
        rst = rs; buf_valid = v; out_ready = r; buf_dout = d;
        #1;
    endtask

    task automatic advance();
        bit acc, ren;
        acc = q.size() != 0 && out_ready;
        ren = m_ren();
        if (!rst) begin
            q.delete();
            fc = 0;
        end else begin
            if (acc) begin
                void'(q.pop_front());
                fc = (fc == FL - 1) ? 0 : fc + 1;
            end
            if (ren) for (int k = 0; k < P; k++) q.push_back(buf_dout[(P-1-k)*W +: W]);
        end
    endtask

    task automatic drain();
        for (int i = 0; i < 6; i++) begin
            drive(1, 0, 1, '0);
            advance();
        end
    endtask

    function automatic logic [W*P-1:0] rnd_word();
        return {$urandom(), $urandom()};
    endfunction

    task automatic test_reset();
        for (int i = 0; i < 2; i++) begin
            drive(0, 1, 1, rnd_word());
            n_cmp += 3;
            if (out_valid !== 1'b0) begin n_err++; $display("FAIL reset_valid got %b want 0", out_valid); end
            if (out_data !== '0) begin n_err++; $display("FAIL reset_data got %h want 0", out_data); end
            if (buf_ren !== 1'b0) begin n_err++; $display("FAIL reset_ren got %b want 0", buf_ren); end
            advance();
        end
    endtask

    task automatic test_empty();
        for (int i = 0; i < 10; i++) begin
            drive(1, 0, $urandom_range(0, 1), rnd_word());
            n_cmp += 2;
            if (out_valid !== 1'b0) begin n_err++; $display("FAIL empty_valid cyc %0d got %b want 0", i, out_valid); end
            if (buf_ren !== 1'b0) begin n_err++; $display("FAIL empty_ren cyc %0d got %b want 0", i, buf_ren); end
            advance();
        end
    endtask

    task automatic test_single();
        logic [W-1:0] want [4];
        int rens = 0;
        want[0] = 16'h1111; want[1] = 16'h2222; want[2] = 16'h3333; want[3] = 16'h4444;
        for (int i = 0; i < 7; i++) begin
            drive(1, i == 0, 1, i == 0 ? 64'h1111_2222_3333_4444 : rnd_word());
            rens += int'(buf_ren);
            n_cmp += 2;
            if (out_valid !== (i >= 1 && i <= 4)) begin n_err++; $display("FAIL single_valid cyc %0d got %b", i, out_valid); end
            if (i >= 1 && i <= 4 && out_data !== want[i-1]) begin n_err++; $display("FAIL single_data cyc %0d got %h want %h", i, out_data, want[i-1]); end
            advance();
        end
        n_cmp++;
        if (rens != 1) begin n_err++; $display("FAIL single_ren_count got %0d want 1", rens); end
    endtask

    task automatic test_back_to_back();
        for (int i = 0; i < 14; i++) begin
            drive(1, i < 12, 1, rnd_word());
            n_cmp += 3;
            if (buf_ren !== (i == 0 || i == 4 || i == 8)) begin n_err++; $display("FAIL b2b_ren cyc %0d got %b", i, buf_ren); end
            if (out_valid !== (i >= 1 && i <= 12)) begin n_err++; $display("FAIL b2b_valid cyc %0d got %b", i, out_valid); end
            if (q.size() != 0 && out_data !== q[0]) begin n_err++; $display("FAIL b2b_data cyc %0d got %h want %h", i, out_data, q[0]); end
            advance();
        end
    endtask

    task automatic test_backpressure();
        drive(1, 1, 1, 64'h1111_2222_3333_4444); advance();
        drive(1, 0, 1, '0); advance();
        drive(1, 0, 1, '0); advance();
        for (int i = 0; i < 5; i++) begin
            drive(1, 1, 0, rnd_word());
            n_cmp += 3;
            if (out_data !== 16'h3333) begin n_err++; $display("FAIL bp_data cyc %0d got %h want 3333", i, out_data); end
            if (out_valid !== 1'b1) begin n_err++; $display("FAIL bp_valid cyc %0d got %b want 1", i, out_valid); end
            if (buf_ren !== 1'b0) begin n_err++; $display("FAIL bp_ren cyc %0d got %b want 0", i, buf_ren); end
            advance();
        end
        drive(1, 0, 1, '0); advance();
        drive(1, 0, 1, '0);
        n_cmp++;
        if (out_data !== 16'h4444 || out_valid !== 1'b1) begin n_err++; $display("FAIL bp_resume got %b/%h want 1/4444", out_valid, out_data); end
        advance();
        drain();
    endtask

    task automatic test_mid_reset();
        logic [W*P-1:0] wb;
        wb = rnd_word();
        drive(1, 1, 1, rnd_word()); advance();
        drive(1, 0, 1, '0); advance();
        drive(0, 1, 1, rnd_word());
        n_cmp++;
        if (buf_ren !== 1'b0) begin n_err++; $display("FAIL mrst_ren_in_reset got %b want 0", buf_ren); end
        advance();
        drive(0, 0, 0, '0);
        n_cmp += 3;
        if (out_valid !== 1'b0) begin n_err++; $display("FAIL mrst_valid got %b want 0", out_valid); end
        if (out_data !== '0) begin n_err++; $display("FAIL mrst_data got %h want 0", out_data); end
        if (buf_ren !== 1'b0) begin n_err++; $display("FAIL mrst_ren got %b want 0", buf_ren); end
        advance();
        drive(1, 1, 0, wb);
        n_cmp++;
        if (buf_ren !== 1'b1) begin n_err++; $display("FAIL mrst_reload_ren got %b want 1", buf_ren); end
        advance();
        drive(1, 0, 1, '0);
        n_cmp++;
        if (out_valid !== 1'b1 || out_data !== wb[W*P-1 -: W]) begin n_err++; $display("FAIL mrst_first got %b/%h want 1/%h", out_valid, out_data, wb[W*P-1 -: W]); end
        advance();
        drain();
    endtask

    task automatic test_random();
        for (int i = 0; i < 400; i++) begin
            drive($urandom_range(0, 24) != 0, $urandom_range(0, 2) != 0, $urandom_range(0, 3) != 0, rnd_word());
            n_cmp += 3;
            if (buf_ren !== m_ren()) begin n_err++; $display("FAIL rnd_ren cyc %0d got %b want %b", i, buf_ren, m_ren()); end
            if (out_valid !== (q.size() != 0)) begin n_err++; $display("FAIL rnd_valid cyc %0d got %b want %b", i, out_valid, q.size() != 0); end
            if (q.size() != 0 && out_data !== q[0]) begin n_err++; $display("FAIL rnd_data cyc %0d got %h want %h", i, out_data, q[0]); end
`ifdef BUFFER_DRAIN_LAST_EN
            n_cmp++;
            if (out_last !== m_last()) begin n_err++; $display("FAIL rnd_last cyc %0d got %b want %b", i, out_last, m_last()); end
`endif
            advance();
        end
        drain();
    endtask

`ifdef BUFFER_DRAIN_LAST_EN
    task automatic test_last();
        int acc_n = 0;
        int lasts = 0;
        drive(0, 0, 0, '0); advance();
        for (int i = 0; i < 24; i++) begin
            drive(1, i < 20, 1, rnd_word());
            n_cmp++;
            if (out_last !== m_last()) begin n_err++; $display("FAIL last cyc %0d got %b want %b", i, out_last, m_last()); end
            if (out_valid) begin
                acc_n++;
                if (out_last) begin
                    lasts++;
                    n_cmp++;
                    if (acc_n % FL != 0) begin n_err++; $display("FAIL last_pos got element %0d want multiple of %0d", acc_n, FL); end
                end
            end
            advance();
        end
        n_cmp++;
        if (lasts != 2) begin n_err++; $display("FAIL last_count got %0d want 2", lasts); end
    endtask
`endif

    initial begin
        test_reset();
        test_empty();
        test_single();
        test_back_to_back();
        test_backpressure();
        test_mid_reset();
        test_random();
`ifdef BUFFER_DRAIN_LAST_EN
        test_last();
`endif
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
